// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// - size_t / SIZE_*: request access-size encoding (byte, half, word, reserved).
// - state_t / IDLE..RESP: FSM state encoding used by lsu.
// - req_error(): alignment / reserved-size check applied when a request is accepted.
package lsu_pkg;

  typedef logic [1:0] size_t;
  localparam size_t SIZE_B = 2'd0;
  localparam size_t SIZE_H = 2'd1;
  localparam size_t SIZE_W = 2'd2;
  localparam size_t SIZE_R = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t READ  = 2'd1;
  localparam state_t WRITE = 2'd2;
  localparam state_t RESP  = 2'd3;

  // 1 when the request must be answered with an error and no memory access.
  function automatic logic req_error(input size_t size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SIZE_B:  err = 1'b0;
      SIZE_H:  err = addr_lo[0];
      SIZE_W:  err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit (purely combinational).
// Ports:
//   offset      byte offset of the access inside the word (addr[1:0])
//   size        access size (SIZE_B / SIZE_H / SIZE_W)
//   is_unsigned 1 = zero-extend loads, 0 = sign-extend
//   rword       word read from memory
//   wdata       right-aligned store data
//   load_data   selected lane shifted to bit 0 and extended
//   merge_data  rword with the addressed lanes replaced by wdata
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       offset,
  input  size_t            size,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] rword,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] merge_data
);

  logic [WIDTH-1:0] lane_s;
  logic             sign_b_s;
  logic             sign_h_s;

  // Load path: move the addressed lane down to bit 0, then extend it.
  always_comb begin
    lane_s    = rword >> {offset, 3'b000};
    sign_b_s  = ~is_unsigned & lane_s[7];
    sign_h_s  = ~is_unsigned & lane_s[15];
    load_data = rword;
    case (size)
      SIZE_B:  load_data = {{(WIDTH-8){sign_b_s}}, lane_s[7:0]};
      SIZE_H:  load_data = {{(WIDTH-16){sign_h_s}}, lane_s[15:0]};
      default: load_data = rword;
    endcase
  end

  // Store path: overwrite only the addressed lanes of the fetched word.
  always_comb begin
    merge_data = rword;
    case (size)
      SIZE_B:  merge_data[{offset, 3'b000} +: 8]     = wdata[7:0];
      SIZE_H:  merge_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between a valid/ready requester and a simple word memory.
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   req_valid_i / req_ready_o         request handshake (ready only in IDLE)
//   req_we_i, req_addr_i, req_size_i  store flag, byte address, access size
//   req_unsigned_i, req_wdata_i       load extension mode, store data
//   rsp_valid_o / rsp_ready_i         response handshake
//   rsp_rdata_o, rsp_err_o            extended load data, error flag
//   mem_read_*                        read request (held until mem_read_valid_i)
//   mem_write_*                       single-cycle full-word write strobe
// Sub-word stores are read-modify-write; word stores write directly.
module lsu
  import lsu_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH) + 2,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [AW-1:0]    req_addr_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             mem_read_en_o,
  output logic [PW-1:0]    mem_read_pos_o,
  input  logic [WIDTH-1:0] mem_read_data_i,
  input  logic             mem_read_valid_i,
  output logic             mem_write_en_o,
  output logic [PW-1:0]    mem_write_pos_o,
  output logic [WIDTH-1:0] mem_write_data_o
);

  state_t           state_r;
  logic             we_r;
  logic [AW-1:0]    addr_r;
  size_t            size_r;
  logic             uns_r;
  logic [WIDTH-1:0] wdata_r;

  logic             req_ready_r;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_rdata_r;
  logic             rsp_err_r;
  logic             mem_read_en_r;
  logic [PW-1:0]    mem_read_pos_r;
  logic             mem_write_en_r;
  logic [PW-1:0]    mem_write_pos_r;
  logic [WIDTH-1:0] mem_write_data_r;

  logic [WIDTH-1:0] load_data_s;
  logic [WIDTH-1:0] merge_data_s;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .offset      (addr_r[1:0]),
    .size        (size_r),
    .is_unsigned (uns_r),
    .rword       (mem_read_data_i),
    .wdata       (wdata_r),
    .load_data   (load_data_s),
    .merge_data  (merge_data_s)
  );

  // Control FSM; every externally visible output is a register updated here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r          <= IDLE;
      we_r             <= 1'b0;
      addr_r           <= '0;
      size_r           <= SIZE_B;
      uns_r            <= 1'b0;
      wdata_r          <= '0;
      req_ready_r      <= 1'b0;
      rsp_valid_r      <= 1'b0;
      rsp_rdata_r      <= '0;
      rsp_err_r        <= 1'b0;
      mem_read_en_r    <= 1'b0;
      mem_read_pos_r   <= '0;
      mem_write_en_r   <= 1'b0;
      mem_write_pos_r  <= '0;
      mem_write_data_r <= '0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      mem_write_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid_i && req_ready_r) begin
            req_ready_r <= 1'b0;
            we_r        <= req_we_i;
            addr_r      <= req_addr_i;
            size_r      <= req_size_i;
            uns_r       <= req_unsigned_i;
            wdata_r     <= req_wdata_i;
            if (req_error(req_size_i, req_addr_i[1:0])) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= '0;
            end else if (req_we_i && (req_size_i == SIZE_W)) begin
              state_r          <= WRITE;
              mem_write_en_r   <= 1'b1;
              mem_write_pos_r  <= req_addr_i[AW-1:2];
              mem_write_data_r <= req_wdata_i;
            end else begin
              // Loads and sub-word stores both need the current word first.
              state_r        <= READ;
              mem_read_en_r  <= 1'b1;
              mem_read_pos_r <= req_addr_i[AW-1:2];
            end
          end else begin
            // Also raises ready on the first edge after reset release.
            req_ready_r <= 1'b1;
          end
        end
        READ: begin
          if (mem_read_valid_i) begin
            mem_read_en_r <= 1'b0;
            if (we_r) begin
              state_r          <= WRITE;
              mem_write_en_r   <= 1'b1;
              mem_write_pos_r  <= addr_r[AW-1:2];
              mem_write_data_r <= merge_data_s;
            end else begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b0;
              rsp_rdata_r <= load_data_s;
            end
          end else begin
            mem_read_en_r <= 1'b1;
          end
        end
        WRITE: begin
          state_r     <= RESP;
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= '0;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
            req_ready_r <= 1'b1;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= IDLE;
          req_ready_r   <= 1'b0;
          rsp_valid_r   <= 1'b0;
          mem_read_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o      = req_ready_r;
  assign rsp_valid_o      = rsp_valid_r;
  assign rsp_rdata_o      = rsp_rdata_r;
  assign rsp_err_o        = rsp_err_r;
  assign mem_read_en_o    = mem_read_en_r;
  assign mem_read_pos_o   = mem_read_pos_r;
  assign mem_write_en_o   = mem_write_en_r;
  assign mem_write_pos_o  = mem_write_pos_r;
  assign mem_write_data_o = mem_write_data_r;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the stimulus task computes each expected
// response, write and read from a byte-level reference model and queues
// them; a negedge monitor pops and compares whenever the DUT shows them.
module tb_lsu;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 6;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready_o;
  logic             req_we = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [1:0]       req_size = 2'd0;
  logic             req_uns = 1'b0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic             rsp_valid_o;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_rdata_o;
  logic             rsp_err_o;
  logic             mem_read_en_o;
  logic [PW-1:0]    mem_read_pos_o;
  logic [WIDTH-1:0] mem_read_data = '0;
  logic             mem_read_valid = 1'b0;
  logic             mem_write_en_o;
  logic [PW-1:0]    mem_write_pos_o;
  logic [WIDTH-1:0] mem_write_data_o;

  lsu #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready_o),
    .req_we_i         (req_we),
    .req_addr_i       (req_addr),
    .req_size_i       (req_size),
    .req_unsigned_i   (req_uns),
    .req_wdata_i      (req_wdata),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_err_o        (rsp_err_o),
    .mem_read_en_o    (mem_read_en_o),
    .mem_read_pos_o   (mem_read_pos_o),
    .mem_read_data_i  (mem_read_data),
    .mem_read_valid_i (mem_read_valid),
    .mem_write_en_o   (mem_write_en_o),
    .mem_write_pos_o  (mem_write_pos_o),
    .mem_write_data_o (mem_write_data_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct packed { logic [3:0] pos; logic [31:0] data; } wr_t;

  rsp_t       exp_rsp[$];
  wr_t        exp_wr[$];
  logic [3:0] exp_rpos[$];
  int         exp_lat[$];

  logic [31:0] mem [DEPTH];      // memory the DUT actually talks to
  logic [31:0] ref_mem [DEPTH];  // reference model view of memory

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int mem_delay = 0;
  int rd_cnt = 0;
  int hold_left = 0;
  bit rdy_random = 1'b0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: answers a read after mem_delay idle cycles, and
  // throws spurious valids outside reads, which the DUT must ignore.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_read_valid = 1'b0;
      rd_cnt = 0;
    end else if (mem_read_en_o) begin
      if (rd_cnt >= mem_delay) begin
        mem_read_valid = 1'b1;
        mem_read_data  = mem[mem_read_pos_o];
        rd_cnt = 0;
      end else begin
        mem_read_valid = 1'b0;
        mem_read_data  = $urandom;
        rd_cnt++;
      end
    end else begin
      mem_read_valid = ($urandom_range(0, 3) == 0);
      mem_read_data  = $urandom;
      rd_cnt = 0;
    end
  end

  // Response-ready driver: optional forced back-pressure, then random or 1.
  always @(posedge clk) begin
    #1;
    if (rsp_valid_o && hold_left > 0) begin
      rsp_ready = 1'b0;
      hold_left--;
    end else begin
      rsp_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  logic        prev_ren = 1'b0;
  logic        prev_rv = 1'b0;
  logic [3:0]  prev_rpos = '0;
  logic [31:0] prev_rdata = '0;
  logic        prev_err = 1'b0;
  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    int   lat;
    if (!rst_n) begin
      prev_ren = 1'b0;
      prev_rv  = 1'b0;
    end else begin
      check32("rd_wr_exclusive", {31'd0, mem_read_en_o & mem_write_en_o}, 32'd0);
      if (mem_read_en_o) begin
        if (!prev_ren) begin
          if (exp_rpos.size() == 0) fail_now("unexpected_read");
          else check32("read_pos", {28'd0, mem_read_pos_o}, {28'd0, exp_rpos.pop_front()});
        end else begin
          check32("read_pos_stable", {28'd0, mem_read_pos_o}, {28'd0, prev_rpos});
        end
      end
      if (mem_write_en_o) begin
        if (exp_wr.size() == 0) fail_now("unexpected_write");
        else begin
          w = exp_wr.pop_front();
          check32("write_pos", {28'd0, mem_write_pos_o}, {28'd0, w.pos});
          check32("write_data", mem_write_data_o, w.data);
        end
        mem[mem_write_pos_o] = mem_write_data_o;
      end
      if (rsp_valid_o) begin
        if (!prev_rv) begin
          if (exp_lat.size() == 0) fail_now("unexpected_rsp");
          else begin
            lat = exp_lat.pop_front();
            check32("latency", 32'(cyc - accept_cyc + 1), 32'(lat));
          end
        end else begin
          check32("rsp_rdata_stable", rsp_rdata_o, prev_rdata);
          check32("rsp_err_stable", {31'd0, rsp_err_o}, {31'd0, prev_err});
        end
        if (rsp_ready) begin
          if (exp_rsp.size() == 0) fail_now("unexpected_rsp_handshake");
          else begin
            r = exp_rsp.pop_front();
            check32("rsp_rdata", rsp_rdata_o, r.rdata);
            check32("rsp_err", {31'd0, rsp_err_o}, {31'd0, r.err});
          end
          last_rdata = rsp_rdata_o;
          last_err   = rsp_err_o;
        end
      end
      prev_ren   = mem_read_en_o;
      prev_rpos  = mem_read_pos_o;
      prev_rv    = rsp_valid_o;
      prev_rdata = rsp_rdata_o;
      prev_err   = rsp_err_o;
    end
  end

  // Wait for IDLE, compute expectations from the reference model, then
  // present one request for exactly the accepting edge. Called at posedge+1.
  task automatic issue(input logic we, input logic [5:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input int delay, input int hold);
    int n;
    int off;
    int nbytes;
    int bits;
    logic [3:0]  pos;
    logic [31:0] word;
    logic [63:0] v;
    logic [63:0] mask;
    rsp_t r;
    wr_t  w;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      fail_now("req_ready_timeout");
      return;
    end
    mem_delay = delay;
    hold_left = hold;
    pos    = addr[5:2];
    off    = int'(addr[1:0]);
    nbytes = 1 << size;
    if (size == 2'd3 || (int'(addr) % nbytes) != 0) begin
      r.rdata = 32'd0; r.err = 1'b1;
      exp_lat.push_back(1);
    end else if (!we) begin
      bits = 8 * nbytes;
      v    = {32'd0, ref_mem[pos]} >> (8 * off);
      mask = (64'd1 << bits) - 64'd1;
      v    = v & mask;
      if (!uns && v[bits-1]) v = v | ~mask;
      r.rdata = v[31:0]; r.err = 1'b0;
      exp_rpos.push_back(pos);
      exp_lat.push_back(2 + delay);
    end else begin
      word = ref_mem[pos];
      for (int i = 0; i < nbytes; i++) word[8*(off+i) +: 8] = wdata[8*i +: 8];
      if (nbytes < 4) begin
        exp_rpos.push_back(pos);
        exp_lat.push_back(3 + delay);
      end else begin
        exp_lat.push_back(2);
      end
      w.pos = pos; w.data = word;
      exp_wr.push_back(w);
      ref_mem[pos] = word;
      r.rdata = 32'd0; r.err = 1'b0;
    end
    exp_rsp.push_back(r);
    req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    req_valid = 1'b0;
    // Fields must be ignored once captured.
    req_we = 1'($urandom); req_addr = 6'($urandom); req_size = 2'($urandom);
    req_uns = 1'($urandom); req_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || req_ready_o !== 1'b1) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) fail_now("drain_timeout");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    logic        we;
    logic [5:0]  addr;
    logic [1:0]  size;
    int          sel;
    int          n;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end

    // Reset state.
    #12;
    check32("reset_req_ready", {31'd0, req_ready_o}, 32'd0);
    check32("reset_rsp", {30'd0, rsp_valid_o, rsp_err_o}, 32'd0);
    check32("reset_rdata", rsp_rdata_o, 32'd0);
    check32("reset_mem_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check32("ready_after_reset", {31'd0, req_ready_o}, 32'd1);

    // Word store.
    issue(1'b1, 6'h14, 2'd2, 1'b0, 32'd69, 0, 0);
    drain();
    check32("word_store_mem", mem[5], 32'd69);

    // Sign/zero-extending loads.
    mem[2] = 32'h80FF7F01; ref_mem[2] = 32'h80FF7F01;
    issue(1'b0, 6'h09, 2'd0, 1'b0, 32'd0, 0, 0); drain();
    check32("load_sb_09", last_rdata, 32'h0000007F);
    issue(1'b0, 6'h0B, 2'd0, 1'b0, 32'd0, 0, 0); drain();
    check32("load_sb_0b", last_rdata, 32'hFFFFFF80);
    issue(1'b0, 6'h0A, 2'd1, 1'b1, 32'd0, 0, 0); drain();
    check32("load_uh_0a", last_rdata, 32'h000080FF);

    // Byte store read-modify-write.
    mem[3] = 32'h11223344; ref_mem[3] = 32'h11223344;
    issue(1'b1, 6'h0D, 2'd0, 1'b0, 32'h000000AA, 0, 0); drain();
    check32("byte_store_mem", mem[3], 32'h1122AA44);

    // Errors.
    issue(1'b0, 6'h03, 2'd1, 1'b0, 32'd0, 0, 0); drain();
    check32("err_half_misaligned", {31'd0, last_err}, 32'd1);
    issue(1'b1, 6'h00, 2'd3, 1'b0, 32'h12345678, 0, 0); drain();
    check32("err_size3", {31'd0, last_err}, 32'd1);

    // Slow memory plus response back-pressure.
    issue(1'b0, 6'h08, 2'd2, 1'b0, 32'd0, 4, 3); drain();
    check32("slow_word_load", last_rdata, 32'h80FF7F01);

    // Reset while the sub-word store is in WRITE.
    saved = ref_mem[6];
    issue(1'b1, 6'h1A, 2'd1, 1'b0, 32'h0000BEEF, 0, 0);
    n = 0;
    while (mem_write_en_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) fail_now("reach_write_timeout");
    rst_n = 1'b0;
    exp_rsp.delete(); exp_wr.delete(); exp_rpos.delete(); exp_lat.delete();
    ref_mem[6] = saved;
    #1;
    check32("rst_write_en", {31'd0, mem_write_en_o}, 32'd0);
    check32("rst_outputs", {28'd0, req_ready_o, rsp_valid_o, rsp_err_o, mem_read_en_o}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check32("rst_ready_after", {31'd0, req_ready_o}, 32'd1);
    check32("rst_mem_untouched", mem[6], saved);

    // Randomized traffic.
    rdy_random = 1'b1;
    for (int k = 0; k < 250; k++) begin
      we   = 1'($urandom);
      sel  = $urandom_range(0, 9);
      size = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      addr = 6'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      issue(we, addr, size, 1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end
    drain();
    check32("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check32("rpos_queue_empty", 32'(exp_rpos.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++) check32("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
